// File: rtl/rom_dl_seq.sv
// ROM download sequencer.
// Takes the HPS ioctl byte stream, turns it into registered ROM bank
// writes, checks that the image arrived complete, and controls the
// game-core reset. The core reset is released only after a good load
// followed by a fixed hold period.
//
// ioctl_wr is a one-cycle valid strobe with no ready/back-pressure. Every
// strobe is either consumed or dropped in the cycle it is seen, and the
// matching ROMEN pulse follows exactly one cycle later.
module rom_dl_seq #(
  parameter int unsigned EXPECT_BYTES = 32768,
  parameter int unsigned HOLD_CYCLES  = 16
) (
  input  logic        clk_sys,
  input  logic        RESET_N,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        EXT_RST,
  output logic        ROMEN,
  output logic [2:0]  ROMSEL,
  output logic [12:0] ROMAD,
  output logic [7:0]  ROMDT,
  output logic        CORE_RST,
  output logic        DL_ERR,
  output logic        DL_BUSY,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_HOLD = 3'd2,
    S_RUN  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [24:0] EXP_ADDR  = 25'(EXPECT_BYTES);
  localparam logic [16:0] EXP_CNT   = 17'(EXPECT_BYTES);
  // A zero hold length still spends one cycle in HOLD.
  localparam logic [31:0] HOLD_LAST = (HOLD_CYCLES == 0) ? 32'd0 : 32'(HOLD_CYCLES - 1);

  state_t      state, state_d;
  logic        dl_q;
  logic        dl_arm;
  logic [16:0] cnt, cnt_d, cnt_base;
  logic        ovr, ovr_d;
  logic [31:0] hold_cnt, hold_cnt_d;

  logic        dl_rise, dl_fall;
  logic        wr_active, in_range, wr_accept, wr_over;

  logic        romen_d;
  logic [2:0]  romsel_d;
  logic [12:0] romad_d;
  logic [7:0]  romdt_d;
  logic        core_rst_d, dl_err_d, dl_busy_d;

  // dl_arm blocks a false rise when download is still high coming out
  // of reset; it becomes set once download has been seen low.
  assign dl_rise   = ioctl_download & ~dl_q & dl_arm;
  assign dl_fall   = ~ioctl_download & dl_q;
  assign in_range  = (ioctl_addr < EXP_ADDR);
  assign wr_active = ioctl_wr & ((state == S_LOAD) | dl_rise);
  assign wr_accept = wr_active & in_range;
  assign wr_over   = wr_active & ~in_range;
  assign dbg_state = state;

  // Byte counter and overrun flag: a new download restarts both, and a
  // write arriving in the same cycle is already included.
  always_comb begin
    cnt_base = dl_rise ? 17'd0 : cnt;
    cnt_d    = cnt_base;
    if (wr_accept && (cnt_base != 17'h1FFFF)) begin
      cnt_d = cnt_base + 17'd1;
    end
    ovr_d = (dl_rise ? 1'b0 : ovr) | wr_over;
  end

  // State register, edge detector, counters.
  always_ff @(posedge clk_sys) begin
    if (!RESET_N) begin
      state    <= S_IDLE;
      dl_q     <= 1'b0;
      dl_arm   <= ~ioctl_download;
      cnt      <= 17'd0;
      ovr      <= 1'b0;
      hold_cnt <= 32'd0;
    end else begin
      state    <= state_d;
      dl_q     <= ioctl_download;
      dl_arm   <= dl_arm | ~ioctl_download;
      cnt      <= cnt_d;
      ovr      <= ovr_d;
      hold_cnt <= hold_cnt_d;
    end
  end

  // Next-state logic: a download start wins from any state.
  always_comb begin
    state_d = state;
    if (dl_rise) begin
      state_d = S_LOAD;
    end else begin
      case (state)
        S_LOAD: begin
          if (dl_fall) begin
            state_d = ((cnt_d == EXP_CNT) && !ovr_d) ? S_HOLD : S_ERR;
          end
        end
        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) state_d = S_RUN;
        end
        default: state_d = state;
      endcase
    end
    hold_cnt_d = ((state == S_HOLD) && (state_d == S_HOLD)) ? hold_cnt + 32'd1 : 32'd0;
  end

  // Output values for the next cycle, derived from the next state so the
  // registered outputs line up with the state they describe.
  always_comb begin
    romen_d    = wr_accept;
    romsel_d   = wr_accept ? ioctl_addr[15:13] : ROMSEL;
    romad_d    = wr_accept ? ioctl_addr[12:0]  : ROMAD;
    romdt_d    = wr_accept ? ioctl_dout        : ROMDT;
    core_rst_d = (state_d == S_RUN) ? EXT_RST : 1'b1;
    dl_err_d   = (state_d == S_ERR);
    dl_busy_d  = (state_d == S_LOAD) || (state_d == S_HOLD);
  end

  // Output registers.
  always_ff @(posedge clk_sys) begin
    if (!RESET_N) begin
      ROMEN    <= 1'b0;
      ROMSEL   <= 3'd0;
      ROMAD    <= 13'd0;
      ROMDT    <= 8'd0;
      CORE_RST <= 1'b1;
      DL_ERR   <= 1'b0;
      DL_BUSY  <= 1'b0;
    end else begin
      ROMEN    <= romen_d;
      ROMSEL   <= romsel_d;
      ROMAD    <= romad_d;
      ROMDT    <= romdt_d;
      CORE_RST <= core_rst_d;
      DL_ERR   <= dl_err_d;
      DL_BUSY  <= dl_busy_d;
    end
  end

endmodule

// File: tb/tb_rom_dl_seq.sv
// Bench for rom_dl_seq: a full-size instance and a small instance
// (4-byte image, zero hold) share the same stimulus; sel picks which one
// is observed.
module tb_rom_dl_seq;

  // ---------------- clock / reset ----------------
  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        RESET_N, ioctl_download, ioctl_wr, EXT_RST;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  logic        b_romen, b_core, b_err, b_busy;
  logic [2:0]  b_romsel, b_dbg;
  logic [12:0] b_romad;
  logic [7:0]  b_romdt;
  logic        s_romen, s_core, s_err, s_busy;
  logic [2:0]  s_romsel, s_dbg;
  logic [12:0] s_romad;
  logic [7:0]  s_romdt;

  rom_dl_seq u_big (
    .clk_sys(clk_sys), .RESET_N(RESET_N), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .EXT_RST(EXT_RST), .ROMEN(b_romen), .ROMSEL(b_romsel), .ROMAD(b_romad),
    .ROMDT(b_romdt), .CORE_RST(b_core), .DL_ERR(b_err), .DL_BUSY(b_busy),
    .dbg_state(b_dbg)
  );

  rom_dl_seq #(.EXPECT_BYTES(4), .HOLD_CYCLES(0)) u_small (
    .clk_sys(clk_sys), .RESET_N(RESET_N), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .EXT_RST(EXT_RST), .ROMEN(s_romen), .ROMSEL(s_romsel), .ROMAD(s_romad),
    .ROMDT(s_romdt), .CORE_RST(s_core), .DL_ERR(s_err), .DL_BUSY(s_busy),
    .dbg_state(s_dbg)
  );

  logic        sel;
  logic        mon_romen, mon_core, mon_err, mon_busy;
  logic [2:0]  mon_romsel;
  logic [12:0] mon_romad;
  logic [7:0]  mon_romdt;
  assign mon_romen  = sel ? s_romen  : b_romen;
  assign mon_romsel = sel ? s_romsel : b_romsel;
  assign mon_romad  = sel ? s_romad  : b_romad;
  assign mon_romdt  = sel ? s_romdt  : b_romdt;
  assign mon_core   = sel ? s_core   : b_core;
  assign mon_err    = sel ? s_err    : b_err;
  assign mon_busy   = sel ? s_busy   : b_busy;

  // ---------------- scoreboard / model state ----------------
  int checks = 0;
  int failures = 0;
  logic [23:0] exp_q[$];
  int sb_pulses = 0, sb_bad = 0, sb_extra = 0, sb_miss = 0;
  bit m_loading = 0, m_dl_prev = 0, m_ovr = 0;
  int m_cnt = 0;

  typedef struct {
    bit          dl;
    bit          wr;
    logic [24:0] a;
    logic [7:0]  d;
    bit          ext;
    bit          romen;
    logic [2:0]  rsel;
    logic [12:0] ad;
    logic [7:0]  dt;
    bit          core;
    bit          busy;
    bit          err;
  } vec_t;
  vec_t tbl[15];

  function automatic int m_exp();
    return sel ? 4 : 32768;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, expv);
    end
  endtask

  // One clock; then scoreboard any ROM write seen on the observed instance.
  task automatic step();
    logic [23:0] w;
    @(posedge clk_sys);
    #1;
    if (mon_romen === 1'b1) begin
      if (exp_q.size() == 0) sb_extra++;
      else begin
        w = exp_q.pop_front();
        sb_pulses++;
        if ({mon_romsel, mon_romad, mon_romdt} !== w) sb_bad++;
      end
    end
    if (exp_q.size() != 0) begin
      sb_miss += exp_q.size();
      exp_q.delete();
    end
  endtask

  // Drive one cycle of ioctl traffic; the model decides from the image
  // rules whether the byte lands in ROM.
  task automatic xfer(input bit dl, input bit we, input logic [24:0] a, input logic [7:0] d);
    ioctl_download = dl;
    ioctl_wr       = we;
    ioctl_addr     = a;
    ioctl_dout     = d;
    if (!RESET_N) begin
      m_loading = 0;
      m_cnt     = 0;
      m_ovr     = 0;
    end else begin
      if (dl && !m_dl_prev) begin
        m_loading = 1;
        m_cnt     = 0;
        m_ovr     = 0;
      end
      if (m_loading && we) begin
        if (int'(a) < m_exp()) begin
          exp_q.push_back({a[15:0], d});
          m_cnt++;
        end else m_ovr = 1;
      end
    end
    step();
    if (!dl && m_dl_prev) m_loading = 0;
    m_dl_prev = dl;
    ioctl_wr  = 1'b0;
  endtask

  task automatic sb_check(input string tag, input int exp_pulses);
    check({tag, "_pulses"}, sb_pulses, exp_pulses);
    check({tag, "_data"}, sb_bad, 0);
    check({tag, "_extra"}, sb_extra, 0);
    check({tag, "_miss"}, sb_miss, 0);
    sb_pulses = 0; sb_bad = 0; sb_extra = 0; sb_miss = 0;
  endtask

  // Called right after the download-low cycle: checks hold/run or error.
  task automatic post_fall(input string tag, input bit ext_toggle);
    bit ok;
    int hold_n;
    ok     = (m_cnt == m_exp()) && !m_ovr;
    hold_n = sel ? 1 : 16;
    if (ok) begin
      for (int i = 0; i < hold_n; i++) begin
        check({tag, "_hold"}, {mon_core, mon_busy, mon_err}, 3'b110);
        EXT_RST = (ext_toggle && (i < hold_n - 1)) ? 1'($urandom_range(0, 1)) : 1'b0;
        step();
      end
      check({tag, "_run"}, {mon_core, mon_busy, mon_err}, 3'b000);
      EXT_RST = 1'b1;
      step();
      check({tag, "_ext_on"}, mon_core, 1'b1);
      EXT_RST = 1'b0;
      step();
      check({tag, "_ext_off"}, mon_core, 1'b0);
    end else begin
      check({tag, "_err"}, {mon_core, mon_busy, mon_err}, 3'b101);
      EXT_RST = 1'b1;
      step();
      check({tag, "_err_ext"}, {mon_core, mon_err}, 2'b11);
      EXT_RST = 1'b0;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [24:0] ra;
    logic [7:0]  rd;
    int n;
    bit rw, fw;

    sel = 1'b0; RESET_N = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; EXT_RST = 1'b0;

    tbl[0]  = '{0, 1, 25'd1, 8'hAA, 0, 1'b0, 3'd0, 13'd0, 8'h00, 1, 0, 0};
    tbl[1]  = '{1, 1, 25'd2, 8'h11, 0, 1'b1, 3'd0, 13'd2, 8'h11, 1, 1, 0};
    tbl[2]  = '{1, 0, 25'd0, 8'h00, 0, 1'b0, 3'd0, 13'd2, 8'h11, 1, 1, 0};
    tbl[3]  = '{1, 1, 25'd3, 8'h22, 0, 1'b1, 3'd0, 13'd3, 8'h22, 1, 1, 0};
    tbl[4]  = '{1, 1, 25'd3, 8'h33, 0, 1'b1, 3'd0, 13'd3, 8'h33, 1, 1, 0};
    tbl[5]  = '{0, 1, 25'd0, 8'h44, 0, 1'b1, 3'd0, 13'd0, 8'h44, 1, 1, 0};
    tbl[6]  = '{0, 0, 25'd0, 8'h00, 0, 1'b0, 3'd0, 13'd0, 8'h44, 0, 0, 0};
    tbl[7]  = '{0, 1, 25'd1, 8'h55, 1, 1'b0, 3'd0, 13'd0, 8'h44, 1, 0, 0};
    tbl[8]  = '{0, 0, 25'd0, 8'h00, 0, 1'b0, 3'd0, 13'd0, 8'h44, 0, 0, 0};
    tbl[9]  = '{1, 0, 25'd0, 8'h00, 0, 1'b0, 3'd0, 13'd0, 8'h44, 1, 1, 0};
    tbl[10] = '{1, 1, 25'd4, 8'h66, 0, 1'b0, 3'd0, 13'd0, 8'h44, 1, 1, 0};
    tbl[11] = '{1, 1, 25'd0, 8'h77, 0, 1'b1, 3'd0, 13'd0, 8'h77, 1, 1, 0};
    tbl[12] = '{0, 0, 25'd0, 8'h00, 0, 1'b0, 3'd0, 13'd0, 8'h77, 1, 0, 1};
    tbl[13] = '{0, 1, 25'd1, 8'h88, 1, 1'b0, 3'd0, 13'd0, 8'h77, 1, 0, 1};
    tbl[14] = '{1, 0, 25'd0, 8'h00, 0, 1'b0, 3'd0, 13'd0, 8'h77, 1, 1, 0};

    // Reset values on both instances.
    repeat (3) step();
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      check("rst_romen", mon_romen, 1'b0);
      check("rst_rom_bus", {mon_romsel, mon_romad, mon_romdt}, 24'd0);
      check("rst_flags", {mon_core, mon_busy, mon_err}, 3'b100);
    end
    RESET_N = 1'b1;
    step();

    // Table vectors on the small instance.
    sel = 1'b1;
    for (int i = 0; i < 15; i++) begin
      EXT_RST = tbl[i].ext;
      xfer(tbl[i].dl, tbl[i].wr, tbl[i].a, tbl[i].d);
      check($sformatf("tbl%0d", i),
            {mon_romen, mon_romsel, mon_romad, mon_romdt, mon_core, mon_busy, mon_err},
            {tbl[i].romen, tbl[i].rsel, tbl[i].ad, tbl[i].dt, tbl[i].core, tbl[i].busy, tbl[i].err});
    end
    EXT_RST = 1'b0;
    xfer(0, 0, 25'd0, 8'd0);
    post_fall("tbl_end", 0);
    sb_check("tbl", 5);

    // Out-of-range write with a complete count still fails the image.
    xfer(1, 0, 25'd0, 8'd0);
    for (int a = 0; a < 4; a++) xfer(1, 1, 25'(a), 8'($urandom));
    xfer(1, 1, 25'h8000, 8'h99);
    check("oob_romen", mon_romen, 1'b0);
    xfer(0, 0, 25'd0, 8'd0);
    post_fall("oob", 0);
    sb_check("oob", 4);

    // Random sessions on the small instance.
    for (int s = 0; s < 40; s++) begin
      rw = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 7) == 0) ? 25'h8000 + 25'($urandom_range(0, 255)) : 25'($urandom_range(0, 3));
      xfer(1, rw, ra, 8'($urandom));
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) xfer(1, 0, 25'd0, 8'd0);
        ra = ($urandom_range(0, 7) == 0) ? 25'h8000 + 25'($urandom_range(0, 255)) : 25'($urandom_range(0, 3));
        rd = 8'($urandom);
        xfer(1, 1, ra, rd);
      end
      fw = 1'($urandom_range(0, 1));
      ra = 25'($urandom_range(0, 3));
      xfer(0, fw, ra, 8'($urandom));
      post_fall("rnd", 1);
      sb_check("rnd", m_cnt);
    end

    // Full-size instance: short image, then a complete one.
    sel = 1'b0;
    xfer(1, 0, 25'd0, 8'd0);
    check("short_start", {mon_busy, mon_err, mon_core}, 3'b101);
    for (int a = 0; a < 32767; a++) xfer(1, 1, 25'(a), 8'($urandom));
    xfer(0, 0, 25'd0, 8'd0);
    post_fall("short", 0);
    sb_check("short", 32767);

    xfer(1, 0, 25'd0, 8'd0);
    check("full_start", {mon_busy, mon_err, mon_core}, 3'b101);
    for (int a = 0; a < 32768; a++) begin
      rd = (a == 32'h5A3C) ? 8'h7E : 8'($urandom);
      xfer(1, 1, 25'(a), rd);
      if (a == 32'h5A3C)
        check("addr_split", {mon_romen, mon_romsel, mon_romad, mon_romdt}, {1'b1, 3'd2, 13'h1A3C, 8'h7E});
    end
    xfer(0, 0, 25'd0, 8'd0);
    post_fall("full", 1);
    sb_check("full", 32768);

    // Reset in the middle of a load with download held high.
    xfer(1, 0, 25'd0, 8'd0);
    for (int a = 0; a < 100; a++) xfer(1, 1, 25'(a), 8'($urandom));
    RESET_N = 1'b0;
    xfer(1, 1, 25'd100, 8'h5A);
    check("mid_rst", {mon_romen, mon_busy, mon_core, mon_err}, 4'b0010);
    RESET_N = 1'b1;
    for (int a = 101; a < 111; a++) xfer(1, 1, 25'(a), 8'($urandom));
    check("mid_after", {mon_romen, mon_busy, mon_core, mon_err}, 4'b0010);
    xfer(0, 0, 25'd0, 8'd0);
    check("mid_idle", {mon_busy, mon_core, mon_err}, 3'b010);
    xfer(1, 1, 25'd0, 8'hC3);
    check("mid_reload", {mon_romen, mon_busy}, 2'b11);
    sb_check("mid", 101);

    $display("final state codes big=%0d small=%0d", b_dbg, s_dbg);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rom_dl_seq.md
ROM_DL_SEQ -- requirements
Module: rom_dl_seq

Interface
REQ-001 SHALL have parameter EXPECT_BYTES, default 32768; the exact byte count of a complete ROM image.
REQ-002 SHALL have parameter HOLD_CYCLES, default 16; the number of post-load cycles for which the core is held in reset.
REQ-003 SHALL have port clk_sys, input, 1 bit; the single clock, with all logic on its rising edge.
REQ-004 SHALL have port RESET_N, input, 1 bit; the reset, synchronous and active-low.
REQ-005 SHALL have port ioctl_download, input, 1 bit; high while the HPS is transferring a ROM image.
REQ-006 SHALL have port ioctl_wr, input, 1 bit; a one-cycle byte-valid strobe.
REQ-007 SHALL have port ioctl_addr, input, 25 bits; the byte address within the image.
REQ-008 SHALL have port ioctl_dout, input, 8 bits; the byte data.
REQ-009 SHALL have port EXT_RST, input, 1 bit; the user/OSD reset request, active-high.
REQ-010 SHALL have port ROMEN, output, 1 bit; the registered write strobe to the ROM banks.
REQ-011 SHALL have port ROMSEL, output, 3 bits; the bank select, equal to ioctl_addr[15:13].
REQ-012 SHALL have port ROMAD, output, 13 bits; the address within the bank, equal to ioctl_addr[12:0].
REQ-013 SHALL have port ROMDT, output, 8 bits; the registered write data.
REQ-014 SHALL have port CORE_RST, output, 1 bit; the game-core reset, active-high.
REQ-015 SHALL have port DL_ERR, output, 1 bit; sticky, high when the last image was short, long or out-of-range.
REQ-016 SHALL have port DL_BUSY, output, 1 bit; high in the LOAD and HOLD states.

Function
REQ-017 SHALL implement states IDLE, LOAD, HOLD, RUN and ERR.
REQ-018 SHALL detect dl_rise as ioctl_download high while its registered copy from the previous cycle is low, and dl_fall as the converse.
REQ-019 SHALL, in every state, go to LOAD on dl_rise, clear the byte counter to 0 and clear DL_ERR.
REQ-020 SHALL, in IDLE, hold CORE_RST=1 and stay in IDLE until dl_rise, so the core never runs before an image has loaded.
REQ-021 SHALL, in LOAD, for each ioctl_wr with ioctl_addr < EXPECT_BYTES, drive ROMEN=1 and ROMSEL/ROMAD/ROMDT from the inputs on the next cycle (latency 1), and increment the 17-bit byte counter.
REQ-022 SHALL, in LOAD, set an internal overrun flag and suppress ROMEN for any ioctl_wr with ioctl_addr >= EXPECT_BYTES.
REQ-023 SHALL count repeated writes to the same address individually, and saturate the counter at 17'h1FFFF.
REQ-024 SHALL, on dl_fall in LOAD, go to HOLD if counter == EXPECT_BYTES and overrun is clear, and otherwise go to ERR.
REQ-025 SHALL, on a cycle with dl_fall and ioctl_wr together, accept and count the write before the count comparison.
REQ-026 SHALL, on a cycle with dl_rise and ioctl_wr together, accept and count the write as the first byte.
REQ-027 SHALL, in HOLD, hold CORE_RST=1 and count HOLD_CYCLES cycles, then go to RUN; HOLD_CYCLES=0 SHALL give a single HOLD cycle.
REQ-028 SHALL, in RUN, drive CORE_RST equal to EXT_RST registered (1-cycle latency).
REQ-029 SHALL, in ERR, hold CORE_RST=1 and DL_ERR=1, leaving ERR only on dl_rise.
REQ-030 SHALL force CORE_RST=1 in all states other than RUN, regardless of EXT_RST.
REQ-031 SHALL drive ROMEN only in LOAD, so that ioctl_wr in any other state is ignored.
REQ-032 SHALL register all outputs, with no combinational path from input to output.

Reset
REQ-033 SHALL, with RESET_N=0 at a clock edge, enter IDLE, clear the counter and the overrun flag, and drive ROMEN=0, ROMSEL=0, ROMAD=0, ROMDT=0, CORE_RST=1, DL_ERR=0, DL_BUSY=0.
REQ-034 SHALL, on reset asserted mid-LOAD, abandon the load; if ioctl_download is still high after release, no dl_rise SHALL occur and the block SHALL remain in IDLE.
REQ-035 SHALL initialise the ioctl_download edge register to 0 on reset.

Verification
REQ-036 SHALL verify a full load: 32768 sequential writes, then download low -> ROMEN pulses 32768 times, CORE_RST=1 for 16 HOLD cycles then 0, DL_ERR=0.
REQ-037 SHALL verify a short load: 32767 writes, then download low -> ERR, CORE_RST=1, DL_ERR=1; a following full load clears DL_ERR and reaches RUN.
REQ-038 SHALL verify out-of-range handling: a write at addr 0x8000 during LOAD -> no ROMEN pulse, and ERR at dl_fall even with a 32768 count.
REQ-039 SHALL verify the address split: a write at addr 0x5A3C with data 0x7E -> next cycle ROMSEL=2, ROMAD=0x1A3C, ROMDT=0x7E, ROMEN=1.
REQ-040 SHALL verify reset behaviour: in RUN, EXT_RST=1 gives CORE_RST=1 one cycle later; in HOLD, EXT_RST toggling leaves CORE_RST at 1.
REQ-041 SHALL verify reset mid-LOAD: RESET_N low at write 100 while download stays high -> IDLE, ROMEN=0, no further writes accepted until a new dl_rise.
